// File: rtl/mire_pkg.sv
// Shared types and constants for the grid test-pattern Wishbone writer.
package mire_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        PAUSE = 2'd2
    } mire_state_t;

    typedef logic [31:0] pixel_t;

    localparam pixel_t     WHITE            = 32'h00FF_FFFF;
    localparam pixel_t     BLACK            = 32'h0000_0000;
    localparam logic [2:0] WSHB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WSHB_BTE_LINEAR  = 2'b00;

    // A pixel lies on the grid when either coordinate is a multiple of the pitch.
    function automatic pixel_t grid_pixel(input logic [31:0] px, input logic [31:0] py,
                                          input logic [31:0] mask);
        if (((px & mask) == 32'd0) || ((py & mask) == 32'd0))
            return WHITE;
        else
            return BLACK;
    endfunction

endpackage

// File: rtl/mire_pix_counter.sv
// Raster position, byte address and pixel colour of the pixel currently on the bus.
// Advances once per accepted write and wraps at the end of each frame.
module mire_pix_counter
    import mire_pkg::*;
#(
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          GRID      = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        advance,
    output logic [31:0] adr,
    output pixel_t      pixel,
    output logic        frame_done
);

    localparam int             XW    = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int             YW    = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam logic [XW-1:0]  XMAX  = XW'(HDISP - 1);
    localparam logic [YW-1:0]  YMAX  = YW'(VDISP - 1);
    localparam logic [31:0]    GMASK = 32'(GRID - 1);

    logic [XW-1:0] x;
    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y;
    logic [YW-1:0] y_nxt;
    logic [31:0]   adr_nxt;
    logic          last;

    assign last = (x == XMAX) && (y == YMAX);

    always_comb begin
        x_nxt   = x;
        y_nxt   = y;
        adr_nxt = adr;
        if (advance) begin
            if (x == XMAX) begin
                x_nxt = '0;
                y_nxt = (y == YMAX) ? '0 : y + 1'b1;
            end else begin
                x_nxt = x + 1'b1;
            end
            // Address steps by one word per pixel; the frame wrap reloads the base.
            adr_nxt = last ? BASE_ADDR : adr + 32'd4;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            x          <= '0;
            y          <= '0;
            adr        <= BASE_ADDR;
            pixel      <= WHITE;
            frame_done <= 1'b0;
        end else begin
            x          <= x_nxt;
            y          <= y_nxt;
            adr        <= adr_nxt;
            pixel      <= grid_pixel(32'(x_nxt), 32'(y_nxt), GMASK);
            frame_done <= advance && last;
        end
    end

endmodule

// File: rtl/mire_wshb_writer.sv
// Wishbone B4 classic master filling the frame buffer with a grid pattern, yielding cyc periodically.
// Optional feature: define MIRE_WSHB_RETRY_EN to re-issue a write answered with err or rty.
module mire_wshb_writer
    import mire_pkg::*;
#(
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          GRID      = 16,
    parameter int          PERIOD    = 64
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        enable,
    input  logic        ack,
    input  logic        err,
    input  logic        rty,
    output logic        cyc,
    output logic        stb,
    output logic        we,
    output logic [31:0] adr,
    output logic [31:0] dat_ms,
    output logic [3:0]  sel,
    output logic [2:0]  cti,
    output logic [1:0]  bte,
    output logic        frame_done
);

    localparam int TW = $clog2(PERIOD + 1);

    mire_state_t   state;
    mire_state_t   state_nxt;
    logic          cyc_q;
    logic          cyc_nxt;
    logic          stb_q;
    logic          stb_nxt;
    logic [TW-1:0] tenure;
    logic [TW-1:0] tenure_nxt;
    logic          resp;
    logic          done;
    logic          retry;
    pixel_t        pixel;

    assign resp = (state == WRITE) && stb_q && (ack || err || rty);

`ifdef MIRE_WSHB_RETRY_EN
    assign retry = (state == WRITE) && stb_q && (err || rty);
    assign done  = resp && !retry;
`else
    assign retry = 1'b0;
    assign done  = resp;
`endif

    mire_pix_counter #(
        .HDISP     (HDISP),
        .VDISP     (VDISP),
        .BASE_ADDR (BASE_ADDR),
        .GRID      (GRID)
    ) u_pix_counter (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .advance    (done),
        .adr        (adr),
        .pixel      (pixel),
        .frame_done (frame_done)
    );

    always_comb begin
        state_nxt  = state;
        cyc_nxt    = cyc_q;
        stb_nxt    = stb_q;
        tenure_nxt = tenure;
        case (state)
            IDLE: begin
                cyc_nxt = enable;
                stb_nxt = enable;
                if (enable)
                    state_nxt = WRITE;
            end
            WRITE: begin
                cyc_nxt = 1'b1;
                if (done) begin
                    tenure_nxt = tenure + 1'b1;
                    if (tenure_nxt == TW'(PERIOD)) begin
                        state_nxt = PAUSE;
                        cyc_nxt   = 1'b0;
                        stb_nxt   = 1'b0;
                    end else if (!enable) begin
                        state_nxt = IDLE;
                        cyc_nxt   = 1'b0;
                        stb_nxt   = 1'b0;
                    end else begin
                        stb_nxt = 1'b1;
                    end
                end else begin
                    // A retried write drops stb for one cycle, then the same beat is offered again.
                    stb_nxt = !retry;
                end
            end
            PAUSE: begin
                tenure_nxt = '0;
                cyc_nxt    = enable;
                stb_nxt    = enable;
                state_nxt  = enable ? WRITE : IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cyc_nxt   = 1'b0;
                stb_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state  <= IDLE;
            cyc_q  <= 1'b0;
            stb_q  <= 1'b0;
            tenure <= '0;
        end else begin
            state  <= state_nxt;
            cyc_q  <= cyc_nxt;
            stb_q  <= stb_nxt;
            tenure <= tenure_nxt;
        end
    end

    assign cyc    = cyc_q;
    assign stb    = stb_q;
    assign we     = stb_q;
    assign sel    = stb_q ? 4'hF : 4'h0;
    assign dat_ms = stb_q ? pixel : BLACK;
    assign cti    = WSHB_CTI_CLASSIC;
    assign bte    = WSHB_BTE_LINEAR;

endmodule

// File: tb/tb_mire_wshb_writer.sv
// Scoreboard bench for mire_wshb_writer: a responding slave pushes expected pixels, a monitor checks them.
module tb_mire_wshb_writer;

    localparam int          H    = 32;
    localparam int          V    = 4;
    localparam int          G    = 16;
    localparam int          P    = 8;
    localparam logic [31:0] BASE = 32'h100;
    localparam int          NPIX = H * V;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        enable  = 1'b0;
    logic        ack     = 1'b0;
    logic        err     = 1'b0;
    logic        rty     = 1'b0;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        frame_done;

    mire_wshb_writer #(
        .HDISP     (H),
        .VDISP     (V),
        .BASE_ADDR (BASE),
        .GRID      (G),
        .PERIOD    (P)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .enable     (enable),
        .ack        (ack),
        .err        (err),
        .rty        (rty),
        .cyc        (cyc),
        .stb        (stb),
        .we         (we),
        .adr        (adr),
        .dat_ms     (dat_ms),
        .sel        (sel),
        .cti        (cti),
        .bte        (bte),
        .frame_done (frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        bit          last;
    } exp_t;

    exp_t        expq[$];
    int          checks   = 0;
    int          errors   = 0;
    int          mx       = 0;
    int          my       = 0;
    int          mode     = 0;
    int          wait_cnt = 0;
    bit          err_done = 0;
    int          acc_cnt  = 0;
    int          tcount   = 0;
    bit          mon_en   = 0;
    bit          first    = 1;
    logic [31:0] mem [NPIX];

    function automatic exp_t ref_pixel(int px, int py);
        exp_t r;
        r.adr  = BASE + 32'(4 * (py * H + px));
        r.dat  = ((px % G) == 0 || (py % G) == 0) ? 32'h00FF_FFFF : 32'h0;
        r.last = (px == H - 1) && (py == V - 1);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push_expected();
        expq.push_back(ref_pixel(mx, my));
        mx++;
        if (mx == H) begin
            mx = 0;
            my++;
            if (my == V) my = 0;
        end
    endtask

    task automatic respond_random();
`ifdef MIRE_WSHB_RETRY_EN
        ack = 1'b1;
`else
        case ($urandom_range(0, 5))
            0:       err = 1'b1;
            1:       rty = 1'b1;
            2:       begin ack = 1'b1; err = 1'b1; end
            default: ack = 1'b1;
        endcase
`endif
        push_expected();
    endtask

    // Slave: decides the response for the beat currently on the bus.
    initial begin : slave
        forever begin
            @(posedge sys_clk);
            #1;
            ack = 1'b0;
            err = 1'b0;
            rty = 1'b0;
            if (!sys_rst && stb) begin
                case (mode)
                    0: begin ack = 1'b1; push_expected(); end
                    1: begin
                        if (wait_cnt > 0) wait_cnt--;
                        else begin
                            respond_random();
                            wait_cnt = $urandom_range(0, 5);
                        end
                    end
                    3: begin ack = 1'b1; push_expected(); mode = 2; end
                    4: begin
                        if (mx == 5 && !err_done) begin
                            err = 1'b1;
                            err_done = 1;
                        end else begin
                            ack = 1'b1;
                            push_expected();
                        end
                    end
                    default: ;
                endcase
            end else if (mode == 0) begin
                ack = 1'b1;
            end
        end
    end

    // Monitor: pops expected beats and checks bus protocol on the falling edge.
    initial begin : monitor
        bit          pend;
        bit          fd_exp;
        bit          cyc0_exp;
        bit          cyc1_exp;
        bit          pause_exp;
        bit          gap_exp;
        bit          reissue_exp;
        bit          accepted;
        bit          retried;
        logic [31:0] padr;
        logic [31:0] pdat;
        logic [31:0] radr;
        exp_t        e;
        int          idx;
        pend = 0; fd_exp = 0; cyc0_exp = 0; cyc1_exp = 0; pause_exp = 0;
        gap_exp = 0; reissue_exp = 0; padr = '0; pdat = '0; radr = '0;
        forever begin
            @(negedge sys_clk);
            if (!mon_en) begin
                pend = 0; fd_exp = 0; cyc0_exp = 0; cyc1_exp = 0; pause_exp = 0;
                gap_exp = 0; reissue_exp = 0;
                continue;
            end
            check("frame_done", {31'b0, frame_done}, {31'b0, fd_exp});
            if (cyc0_exp) check("cyc_dropped", {31'b0, cyc}, 32'd0);
            if (cyc1_exp) check("pause_one_cycle", {31'b0, cyc}, 32'd1);
            cyc1_exp  = pause_exp && enable;
            pause_exp = 0;
            cyc0_exp  = 0;
            fd_exp    = 0;
            if (pend) begin
                check("stb_held", {31'b0, stb}, 32'd1);
                check("adr_stable", adr, padr);
                check("dat_stable", dat_ms, pdat);
            end
            if (reissue_exp) begin
                check("reissue_stb", {31'b0, stb}, 32'd1);
                check("reissue_adr", adr, radr);
            end
            reissue_exp = 0;
            if (gap_exp) begin
                check("retry_gap_stb", {31'b0, stb}, 32'd0);
                check("retry_gap_cyc", {31'b0, cyc}, 32'd1);
                reissue_exp = 1;
            end
            gap_exp = 0;
            pend = 0;
            if (cyc && stb) begin
                check("we", {31'b0, we}, 32'd1);
                check("sel", {28'b0, sel}, 32'hF);
`ifdef MIRE_WSHB_RETRY_EN
                accepted = ack && !err && !rty;
                retried  = err || rty;
`else
                accepted = ack || err || rty;
                retried  = 0;
`endif
                if (accepted) begin
                    acc_cnt++;
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: adr %h with no expected beat", adr);
                    end else begin
                        e = expq.pop_front();
                        check("write_adr", adr, e.adr);
                        check("write_dat", dat_ms, e.dat);
                        fd_exp = e.last;
                    end
                    if (first) begin
                        check("first_adr", adr, BASE);
                        check("first_dat", dat_ms, 32'h00FF_FFFF);
                        first = 0;
                    end
                    if (adr == 32'h184) check("pixel_1_1", dat_ms, 32'h0);
                    if (adr == 32'h1C0) check("pixel_16_1", dat_ms, 32'h00FF_FFFF);
                    idx = int'((adr - BASE) >> 2);
                    if (idx >= 0 && idx < NPIX) mem[idx] = dat_ms;
                    tcount++;
                    if (tcount == P) begin
                        tcount    = 0;
                        cyc0_exp  = 1;
                        pause_exp = 1;
                    end else if (!enable) begin
                        cyc0_exp = 1;
                    end
                end else if (retried) begin
                    gap_exp = 1;
                    radr    = adr;
                end else begin
                    pend = 1;
                    padr = adr;
                    pdat = dat_ms;
                end
            end
        end
    end

    task automatic wait_accepts(input int n, input int budget);
        int target;
        int k;
        target = acc_cnt + n;
        k = 0;
        while (acc_cnt < target && k < budget) begin
            @(posedge sys_clk);
            k++;
        end
        #2;
        checks++;
        if (acc_cnt < target) begin
            errors++;
            $display("FAIL wait_accepts: got %0d accepts, required %0d", acc_cnt, target);
        end
    endtask

    task automatic wait_stb(input string name);
        int k;
        k = 0;
        while (!stb && k < 50) begin
            @(posedge sys_clk);
            #2;
            k++;
        end
        check(name, {31'b0, stb}, 32'd1);
    endtask

    initial begin : main
        repeat (3) @(posedge sys_clk);
        #2;
        check("rst_cyc", {31'b0, cyc}, 32'd0);
        check("rst_stb", {31'b0, stb}, 32'd0);
        check("rst_we", {31'b0, we}, 32'd0);
        check("rst_adr", adr, BASE);
        check("rst_dat", dat_ms, 32'd0);
        check("rst_sel", {28'b0, sel}, 32'd0);
        check("rst_frame_done", {31'b0, frame_done}, 32'd0);
        sys_rst = 1'b0;
        repeat (2) @(posedge sys_clk);
        #2;
        check("idle_without_enable", {31'b0, cyc}, 32'd0);

        // Continuous ack: two full frames plus a little.
        mon_en = 1;
        enable = 1'b1;
        wait_accepts(2 * NPIX + 10, 1000);
        check("cti", {29'b0, cti}, 32'd0);
        check("bte", {30'b0, bte}, 32'd0);

        // Random ack latency, then compare the whole frame image.
        for (int i = 0; i < NPIX; i++) mem[i] = 32'hDEAD_BEEF;
        mode = 1;
        wait_accepts(2 * NPIX, 6000);
        for (int i = 0; i < NPIX; i++) check("frame_image", mem[i], ref_pixel(i % H, i / H).dat);

        // enable falls while a beat waits for ack.
        mode = 2;
        @(posedge sys_clk);
        #2;
        wait_stb("stb_before_disable");
        enable = 1'b0;
        repeat (3) @(posedge sys_clk);
        #2;
        mode = 3;
        repeat (5) @(posedge sys_clk);
        #2;
        check("idle_cyc", {31'b0, cyc}, 32'd0);
        check("idle_stb", {31'b0, stb}, 32'd0);
        check("queue_drained", 32'(expq.size()), 32'd0);
        enable = 1'b1;
        mode = 1;
        wait_accepts(40, 1000);

        // Asynchronous reset in the middle of a transfer.
        wait_stb("stb_before_reset");
        #1;
        mon_en  = 0;
        sys_rst = 1'b1;
        #1;
        check("async_rst_cyc", {31'b0, cyc}, 32'd0);
        check("async_rst_stb", {31'b0, stb}, 32'd0);
        check("async_rst_adr", adr, BASE);
        check("async_rst_frame_done", {31'b0, frame_done}, 32'd0);
        expq.delete();
        mx = 0;
        my = 0;
        tcount = 0;
        first = 1;
        wait_cnt = 0;
        repeat (2) @(posedge sys_clk);
        #2;
        sys_rst = 1'b0;
        mon_en  = 1;
        wait_accepts(NPIX + 20, 2000);

`ifdef MIRE_WSHB_RETRY_EN
        err_done = 0;
        mode = 4;
        wait_accepts(NPIX + 10, 1000);
        check("retry_injected", {31'b0, err_done}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
